data_ram_ctrl: RTL and testbench
================================

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WORDS_LOG2, default 10, meaning log2 of the backing-store depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of extra wait-state cycles per access (legal range 0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port ce_i, input, 1, access request from the memory stage.
REQ-006 SHALL have port we_i, input, 1, write (1) or read (0).
REQ-007 SHALL have port addr_i, input, 32, byte address; bits [1:0] are ignored (the memory stage aligns).
REQ-008 SHALL have port sel_i, input, 4, byte-lane enables, big-endian: sel_i[3]->data[31:24], sel_i[0]->data[7:0].
REQ-009 SHALL have port data_i, input, 32, store data, already lane-replicated by the requester.
REQ-010 SHALL have port data_o, output, 32, read word returned to the requester.
REQ-011 SHALL have port ready_o, output, 1, one-cycle completion strobe.
REQ-012 SHALL have port stallreq_o, output, 1, pipeline stall request.
REQ-013 SHALL have port err_o, output, 1, access error, valid with ready_o.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-015 In IDLE with ce_i=1, SHALL latch addr_i, we_i, sel_i and data_i, and SHALL enter BUSY with wait counter = WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise it SHALL enter DONE.
REQ-016 stallreq_o SHALL be combinational: 1 when (IDLE and ce_i=1) or BUSY, and 0 in DONE or in IDLE with ce_i=0.
REQ-017 In BUSY, SHALL decrement the counter each cycle and enter DONE in the cycle after the counter reads 0.
REQ-018 Total latency: for a request first presented in cycle N, ready_o SHALL be 1 in cycle N+WAIT_CYCLES+1, with exactly WAIT_CYCLES+1 stall cycles.
REQ-019 In DONE, ready_o SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-020 ce_i in the DONE cycle SHALL be treated as the completing request, not as a new one.
REQ-021 While in BUSY, SHALL ignore changes on all request inputs; the latched request SHALL complete even if ce_i deasserts.
REQ-022 On a write, SHALL update only the lanes whose sel bit is 1 and leave the other bytes unchanged.
REQ-023 The write SHALL be committed on the clock edge entering DONE.
REQ-024 On a read, data_o SHALL present the full 32-bit word regardless of sel_i, valid in the DONE cycle.
REQ-025 data_o SHALL hold its last value until the next read completes.
REQ-026 On a write, data_o SHALL be left unchanged.
REQ-027 Error (out of range): if latched addr[31:ADDR_WORDS_LOG2+2] is nonzero, SHALL suppress the write, set data_o to 0 on a read, and assert err_o in the DONE cycle.
REQ-028 Error (empty select): a write with sel=4'b0000 SHALL change no memory and SHALL assert err_o in the DONE cycle.
REQ-029 A read with sel=4'b0000 SHALL complete normally with no error.
REQ-030 err_o SHALL be 0 whenever ready_o=0.
REQ-031 Word index SHALL be addr[ADDR_WORDS_LOG2+1:2]; there SHALL be no wrap-around because out-of-range addresses error out.

Reset
REQ-032 When rst=1 at a clock edge, SHALL force the state to IDLE, ready_o=0, err_o=0, data_o=32'h0 and the counter to 0.
REQ-033 stallreq_o SHALL be 0 while rst=1, regardless of ce_i.
REQ-034 Reset in BUSY SHALL discard the pending request; no write SHALL occur.
REQ-035 Memory array contents SHALL NOT be reset.

Verification
REQ-036 WAIT_CYCLES=2: write 32'hDEADBEEF to addr 0x10 with sel=1111, then read 0x10 -> stall cycles N..N+2, ready in N+3 of each access, read data_o=32'hDEADBEEF, err_o=0.
REQ-037 After REQ-036, write data_i=32'h55555555 with sel=0100 to 0x10, then read -> data_o=32'hDE55BEEF.
REQ-038 WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4 with ce_i held high -> ready_o pulses in cycles N+1 and N+3, stallreq_o=1 in N and N+2 only.
REQ-039 Read at addr 0x0000_1000 (ADDR_WORDS_LOG2=10) -> ready with err_o=1 and data_o=0; write to the same address -> err_o=1 and word 0 unchanged.
REQ-040 Write 32'h12345678 to 0x20, assert rst in the first BUSY cycle, then read 0x20 -> the old contents are returned, and ready_o/stallreq_o are 0 during reset.
REQ-041 Deassert ce_i in the second BUSY cycle of a read -> the access still completes with ready_o=1 at N+WAIT_CYCLES+1.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - wait-stated data RAM controller with big-endian byte lanes
module data_ram_ctrl #(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        stallreq_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam int DEPTH   = 1 << ADDR_WORDS_LOG2;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:2] addr_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;

  logic [31:0] mem [0:DEPTH-1];

  logic [31:2]                req_addr_d;
  logic                       req_we_d;
  logic [3:0]                 req_sel_d;
  logic [31:0]                req_wdata_d;
  logic [ADDR_WORDS_LOG2-1:0] req_idx_d;
  logic                       req_oob_d;
  logic                       req_err_d;
  logic                       finish_d;
  logic                       do_write_d;
  logic                       unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];

  // With no wait states the access completes straight from IDLE, so the
  // request is taken from the ports rather than from the latched copy.
  always_comb begin
    req_addr_d  = addr_q;
    req_we_d    = we_q;
    req_sel_d   = sel_q;
    req_wdata_d = wdata_q;
    if (state_q == IDLE) begin
      req_addr_d  = addr_i[31:2];
      req_we_d    = we_i;
      req_sel_d   = sel_i;
      req_wdata_d = data_i;
    end
    req_idx_d  = req_addr_d[ADDR_WORDS_LOG2+1:2];
    req_oob_d  = |req_addr_d[31:ADDR_WORDS_LOG2+2];
    req_err_d  = req_oob_d || (req_we_d && (req_sel_d == 4'b0000));
    finish_d   = !rst && (((state_q == IDLE) && ce_i && NO_WAIT) ||
                          ((state_q == BUSY) && (cnt_q == 4'd0)));
    do_write_d = finish_d && req_we_d && !req_err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (finish_d) begin
        ready_q <= 1'b1;
        err_q   <= req_err_d;
        if (!req_we_d) begin
          rdata_q <= req_oob_d ? 32'h0 : mem[req_idx_d];
        end
      end
      case (state_q)
        IDLE: begin
          if (ce_i) begin
            addr_q  <= addr_i[31:2];
            we_q    <= we_i;
            sel_q   <= sel_i;
            wdata_q <= data_i;
            if (NO_WAIT) begin
              state_q <= DONE;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Backing store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_write_d) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel_d[b]) begin
          mem[req_idx_d][8*b +: 8] <= req_wdata_d[8*b +: 8];
        end
      end
    end
  end

  assign stallreq_o = !rst && (((state_q == IDLE) && ce_i) || (state_q == BUSY));
  assign data_o     = rdata_q;
  assign ready_o    = ready_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - scoreboard bench for data_ram_ctrl at WAIT_CYCLES 2 and 0
module tb_data_ram_ctrl;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic        ce2, we2, ready2, stall2, err2;
  logic [31:0] addr2, wd2, data2;
  logic [3:0]  sel2;
  logic        ce0, we0, ready0, stall0, err0;
  logic [31:0] addr0, wd0, data0;
  logic [3:0]  sel0;

  exp_t        q2[$];
  exp_t        q0[$];
  logic [31:0] last2 = 32'h0;
  logic [31:0] last0 = 32'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_ctrl #(.ADDR_WORDS_LOG2(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .ce_i(ce2), .we_i(we2), .addr_i(addr2), .sel_i(sel2),
    .data_i(wd2), .data_o(data2), .ready_o(ready2), .stallreq_o(stall2), .err_o(err2));

  data_ram_ctrl #(.ADDR_WORDS_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we0), .addr_i(addr0), .sel_i(sel0),
    .data_i(wd0), .data_o(data0), .ready_o(ready0), .stallreq_o(stall0), .err_o(err0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      if (ready2) begin
        if (q2.size() == 0) chk("w2_unexpected_ready", 32'(ready2), 32'd0);
        else begin
          e = q2.pop_front();
          chk("w2_ready_cycle", 32'(cyc), 32'(e.cyc));
          chk("w2_data", data2, e.data);
          chk("w2_err", 32'(err2), 32'(e.err));
        end
      end else begin
        chk("w2_err_without_ready", 32'(err2), 32'd0);
        if (q2.size() > 0 && cyc > q2[0].cyc) begin
          chk("w2_ready_timeout", 32'(cyc), 32'(q2[0].cyc));
          void'(q2.pop_front());
        end
      end
      if (ready0) begin
        if (q0.size() == 0) chk("w0_unexpected_ready", 32'(ready0), 32'd0);
        else begin
          e = q0.pop_front();
          chk("w0_ready_cycle", 32'(cyc), 32'(e.cyc));
          chk("w0_data", data0, e.data);
          chk("w0_err", 32'(err0), 32'(e.err));
        end
      end else begin
        chk("w0_err_without_ready", 32'(err0), 32'd0);
        if (q0.size() > 0 && cyc > q0[0].cyc) begin
          chk("w0_ready_timeout", 32'(cyc), 32'(q0[0].cyc));
          void'(q0.pop_front());
        end
      end
    end
  end

  task automatic acc2(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] wd, input logic [31:0] rd_exp, input logic err_exp);
    exp_t e;
    if (!we) last2 = rd_exp;
    e.cyc  = cyc + 3;
    e.data = last2;
    e.err  = err_exp;
    q2.push_back(e);
    ce2 = 1'b1; we2 = we; addr2 = addr; sel2 = sel; wd2 = wd;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("w2_stall", 32'(stall2), 32'(i < 3));
      @(posedge clk); #1;
      if (i == 1) begin
        ce2 = 1'b0; we2 = ~we; addr2 = 32'hFFFF_FFFC; sel2 = ~sel; wd2 = ~wd;
      end
    end
  endtask

  task automatic acc0(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] wd, input logic [31:0] rd_exp, input logic err_exp);
    exp_t e;
    if (!we) last0 = rd_exp;
    e.cyc  = cyc + 1;
    e.data = last0;
    e.err  = err_exp;
    q0.push_back(e);
    ce0 = 1'b1; we0 = we; addr0 = addr; sel0 = sel; wd0 = wd;
    @(negedge clk); chk("w0_stall_req", 32'(stall0), 32'd1);
    @(posedge clk); #1; ce0 = 1'b0;
    @(negedge clk); chk("w0_stall_done", 32'(stall0), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    ce2 = 1'b1; we2 = 1'b0; addr2 = 32'h0; sel2 = 4'hF; wd2 = 32'h0;
    ce0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; sel0 = 4'hF; wd0 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready2", 32'(ready2), 32'd0);
    chk("rst_err2", 32'(err2), 32'd0);
    chk("rst_data2", data2, 32'h0);
    chk("rst_stall2", 32'(stall2), 32'd0);
    chk("rst_stall0", 32'(stall0), 32'd0);
    chk("rst_data0", data0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; ce2 = 1'b0; ce0 = 1'b0;
    @(posedge clk); #1;

    // Zero wait states: init two words, then back-to-back reads with ce held high.
    acc0(1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0);
    acc0(1'b1, 32'h4, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
    e.cyc = cyc + 1; e.data = 32'h0BAD_F00D; e.err = 1'b0; q0.push_back(e);
    e.cyc = cyc + 3; e.data = 32'hCAFE_F00D; e.err = 1'b0; q0.push_back(e);
    last0 = 32'hCAFE_F00D;
    ce0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; sel0 = 4'hF;
    @(negedge clk); chk("b2b_stall_n", 32'(stall0), 32'd1);
    @(posedge clk); #1; addr0 = 32'h4;
    @(negedge clk); chk("b2b_stall_n1", 32'(stall0), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_stall_n2", 32'(stall0), 32'd1);
    @(posedge clk); #1; ce0 = 1'b0;
    @(negedge clk); chk("b2b_stall_n3", 32'(stall0), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_idle_ready", 32'(ready0), 32'd0);
    @(posedge clk); #1;

    // Two wait states.
    acc2(1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
    acc2(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);
    acc2(1'b1, 32'h10, 4'b0100, 32'h5555_5555, 32'h0, 1'b0);
    acc2(1'b0, 32'h10, 4'b0000, 32'h0, 32'hDE55_BEEF, 1'b0);
    acc2(1'b1, 32'h0, 4'b1111, 32'hA5A5_A5A5, 32'h0, 1'b0);
    acc2(1'b0, 32'h0000_1000, 4'b1111, 32'h0, 32'h0, 1'b1);
    acc2(1'b1, 32'h0000_1000, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b1);
    acc2(1'b0, 32'h0, 4'b1111, 32'h0, 32'hA5A5_A5A5, 1'b0);
    acc2(1'b1, 32'h0, 4'b0000, 32'h0000_0000, 32'h0, 1'b1);
    acc2(1'b0, 32'h0, 4'b0011, 32'h0, 32'hA5A5_A5A5, 1'b0);
    acc2(1'b1, 32'h20, 4'b1111, 32'h1111_1111, 32'h0, 1'b0);

    // Reset lands in the first BUSY cycle of a write; the write must be dropped.
    ce2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; sel2 = 4'hF; wd2 = 32'h1234_5678;
    @(negedge clk); chk("rstbusy_stall_req", 32'(stall2), 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rstbusy_stall", 32'(stall2), 32'd0);
    chk("rstbusy_ready", 32'(ready2), 32'd0);
    @(posedge clk); #1; rst = 1'b0; ce2 = 1'b0;
    last2 = 32'h0; last0 = 32'h0;
    @(negedge clk);
    chk("after_rst_ready", 32'(ready2), 32'd0);
    chk("after_rst_data", data2, 32'h0);
    chk("after_rst_stall", 32'(stall2), 32'd0);
    @(posedge clk); #1;
    acc2(1'b0, 32'h20, 4'b1111, 32'h0, 32'h1111_1111, 1'b0);
    acc0(1'b0, 32'h4, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0);

    repeat (6) @(posedge clk);
    #1;
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
